ecc_secded_pipe: RTL and testbench
==================================

Name: ecc_secded_pipe

Overview:
Pipelined, parametrised SEC-DED decoder/corrector for a streaming data path. It is the clocked successor to the team's 32-bit combinational single-error-correcting block. It adds a width parameter, double-error detection, valid/ready flow control, saturating error counters and a first-error syndrome log. It sits between the storage/link receive side and consumers, one word per cycle at full rate.

Parameters:
DATA_W, 32, data word width (>=4)
CNT_W, 16, width of each saturating error counter
R (localparam), derived, smallest r with 2^r >= DATA_W+r+1 (6 for 32)
CHK_W (localparam), R+1, Hamming check bits plus overall parity bit

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input word valid
in_ready  out  1  block can accept input this cycle
in_data  in  DATA_W  received data
in_chk  in  CHK_W  received check bits; [R] is overall parity
corr_en  in  1  per-word correction enable, sampled with in_data
out_valid  out  1  output word valid
out_ready  in  1  consumer accepts output
out_data  out  DATA_W  corrected or passed-through data
out_err_single  out  1  single-bit error detected on this word
out_err_double  out  1  uncorrectable error detected on this word
out_syndrome  out  R  Hamming syndrome of this word
cnt_single  out  CNT_W  saturating count of single errors delivered
cnt_double  out  CNT_W  saturating count of double errors delivered
cnt_clr  in  1  synchronous clear of counters and log
log_valid  out  1  first-error log holds an entry
log_syndrome  out  R  syndrome of first delivered erroneous word
log_double  out  1  first logged error was double

Behaviour:
- Code: codeword positions 1..DATA_W+R. Powers of two hold chk[i], i<R. Data bits fill the remaining positions in ascending order, so data[0] is at position 3. chk[i] = XOR of data bits whose position has bit i set. chk[R] = XOR of all data bits and chk[R-1:0].
- Stage 1 registers syndrome s (recomputed chk XOR received, R bits), overall parity p (XOR of all received bits), data and corr_en.
- Stage 2 classifies and corrects:
  - s=0, p=0: clean.
  - p=1: single error. If s is a data position and corr_en=1, flip that bit; if s=0 or s is a power of two, data is unchanged.
  - p=1 with s > DATA_W+R: treat as double.
  - s!=0, p=0: double. Data passes uncorrected.
  - corr_en=0: never modify data; flags are still reported.
- Latency: 2 cycles from input acceptance to out_valid, with out_ready held high. Throughput is 1 word/cycle.
- Handshake:
  - Transfer occurs when valid&&ready.
  - Each stage advances when its successor is empty or advancing.
  - in_ready is combinational: 1 when stage 1 is empty or advancing, 0 during rst.
  - While out_valid && !out_ready, all out_* stay stable. No word is dropped, duplicated or reordered.
- Counters: increment on output transfer with the matching flag and saturate at all-ones. cnt_clr has priority over a simultaneous increment, giving 0.
- Log: on the first erroneous output transfer while log_valid=0, capture syndrome and type and set log_valid. The log holds until cnt_clr. If cnt_clr and an error transfer coincide, the log is cleared and does not capture that error.
- Reset: all valids, flags, counters, log and syndrome outputs go to 0; out_data goes to 0. rst mid-stream discards in-flight words.

Decomposition:
- Package ecc_pkg:
  - function calc_r(DATA_W)
  - function data_pos(idx) mapping data index to codeword position
  - function is_pow2
  - enum err_class {CLEAN, SINGLE, DOUBLE}
  - an encoder function for the bench to generate chk
- One combinational sub-module, ecc_syndrome_calc (data, chk -> s, p), instantiated in stage 1.
- Classification and counters stay in the top level.

Test Plan:
- data 0x00000000, chk 0, corr_en=1 -> out_data 0x00000000 two cycles later, both flags 0, syndrome 0.
- data 0xA5A5A5A5 encoded, data[7] flipped -> out_data 0xA5A5A5A5, err_single=1, syndrome 0x0C, cnt_single=1, log_valid=1, log_syndrome 0x0C.
- 0xA5A5A5A5 encoded, data[0] and data[1] flipped -> out_data 0xA5A5A5A6, err_double=1, err_single=0, cnt_double=1.
- corr_en=0, data[7] flipped -> out_data 0xA5A5A525 (uncorrected), err_single=1.
- out_ready low for 5 cycles while 4 words are offered back-to-back -> in_ready drops once both stages and the output are full; after release all 4 words emerge in order, stable while stalled.
- CNT_W=2, 5 single errors -> cnt_single stays 3. cnt_clr coincident with the 6th error -> cnt_single 0, log_valid 0. The next error sets the log.

Source files
------------

// File: rtl/ecc_pkg.sv
// ecc_pkg: SEC-DED code geometry, error classes and a reference encoder
package ecc_pkg;
  typedef enum logic [1:0] {CLEAN, SINGLE, DOUBLE} err_class_t;
  localparam int MAX_W = 256;
  localparam int MAX_CHK = 10;
  function automatic int calc_r(input int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction
  function automatic bit is_pow2(input int v);
    return v != 0 && (v & (v - 1)) == 0;
  endfunction
  // Data bits take the non-power-of-two positions from 3 upward
  function automatic int data_pos(input int idx);
    int pos;
    pos = 2;
    for (int k = 0; k <= idx; k++) begin
      pos++;
      while (is_pow2(pos)) pos++;
    end
    return pos;
  endfunction
  function automatic logic [MAX_CHK-1:0] encode(input logic [MAX_W-1:0] data, input int dw);
    int r;
    logic [MAX_CHK-1:0] chk;
    logic par;
    r = calc_r(dw);
    chk = '0;
    par = 1'b0;
    for (int j = 0; j < dw; j++) begin
      if (data[j]) chk ^= MAX_CHK'(data_pos(j));
      par ^= data[j];
    end
    chk[r] = par ^ (^chk);
    return chk;
  endfunction
endpackage

// File: rtl/ecc_secded_pipe_syndrome.sv
// ecc_syndrome_calc: Hamming syndrome and overall parity of a received word
module ecc_syndrome_calc import ecc_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int R = calc_r(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [R:0]        chk,
  output logic [R-1:0]      s,
  output logic              p
);
  logic [R-1:0] pos [DATA_W];
  // Syndrome is the XOR of the positions of all set bits; check bits sit at 2^i
  for (genvar j = 0; j < DATA_W; j++) begin : g_pos
    assign pos[j] = data[j] ? R'(data_pos(j)) : '0;
  end
  always_comb begin
    s = chk[R-1:0];
    for (int j = 0; j < DATA_W; j++) s ^= pos[j];
  end
  assign p = ^{data, chk};
endmodule

// File: rtl/ecc_secded_pipe.sv
// ecc_secded_pipe: two-stage SEC-DED decoder with flow control, counters and error log
module ecc_secded_pipe import ecc_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int CNT_W = 16,
  localparam int R = calc_r(DATA_W),
  localparam int CHK_W = R + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  input  logic              corr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err_single,
  output logic              out_err_double,
  output logic [R-1:0]      out_syndrome,
  output logic [CNT_W-1:0]  cnt_single,
  output logic [CNT_W-1:0]  cnt_double,
  input  logic              cnt_clr,
  output logic              log_valid,
  output logic [R-1:0]      log_syndrome,
  output logic              log_double
);
  localparam logic [R-1:0] LAST = R'(DATA_W + R);
  logic v1, ce1, p1, p_c, en1, en2, xfer;
  logic [R-1:0] s1, s_c;
  logic [DATA_W-1:0] d1, flip;
  err_class_t cls;
  ecc_syndrome_calc #(.DATA_W(DATA_W), .R(R)) u_syn (.data(in_data), .chk(in_chk), .s(s_c), .p(p_c));
  assign en2 = !out_valid || out_ready;
  assign en1 = !v1 || en2;
  assign in_ready = !rst && en1;
  assign xfer = out_valid && out_ready;
  // Odd parity with a syndrome beyond the codeword cannot be a single flip
  assign cls = !v1 ? CLEAN : (p1 && s1 <= LAST) ? SINGLE : (p1 || s1 != '0) ? DOUBLE : CLEAN;
  for (genvar j = 0; j < DATA_W; j++) begin : g_flip
    assign flip[j] = ce1 && cls == SINGLE && s1 == R'(data_pos(j));
  end
  always_ff @(posedge clk)
    if (rst) v1 <= 1'b0;
    else if (en1) begin
      v1 <= in_valid;
      d1 <= in_data;
      s1 <= s_c;
      p1 <= p_c;
      ce1 <= corr_en;
    end
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_err_single <= 1'b0;
      out_err_double <= 1'b0;
      out_syndrome <= '0;
    end else if (en2) begin
      out_valid <= v1;
      out_data <= d1 ^ flip;
      out_err_single <= cls == SINGLE;
      out_err_double <= cls == DOUBLE;
      out_syndrome <= v1 ? s1 : '0;
    end
  always_ff @(posedge clk)
    if (rst || cnt_clr) begin
      cnt_single <= '0;
      cnt_double <= '0;
      log_valid <= 1'b0;
      log_syndrome <= '0;
      log_double <= 1'b0;
    end else if (xfer) begin
      cnt_single <= cnt_single + CNT_W'(out_err_single && !(&cnt_single));
      cnt_double <= cnt_double + CNT_W'(out_err_double && !(&cnt_double));
      if (!log_valid && (out_err_single || out_err_double)) begin
        log_valid <= 1'b1;
        log_syndrome <= out_syndrome;
        log_double <= out_err_double;
      end
    end
endmodule

// File: tb/tb_ecc_secded_pipe.sv
// tb_ecc_secded_pipe: directed vectors checked against a position-XOR SEC-DED model
module tb_ecc_secded_pipe;
  import ecc_pkg::*;
  logic clk = 0, rst = 1, in_valid = 0, corr_en = 0, out_ready = 1, cnt_clr = 0;
  logic [31:0] in_data = '0;
  logic [6:0] in_chk = '0;
  logic in_ready, out_valid, out_err_single, out_err_double, log_valid, log_double;
  logic [31:0] out_data;
  logic [5:0] out_syndrome, log_syndrome;
  logic [1:0] cnt_single, cnt_double;
  typedef struct packed {logic [31:0] d; logic s; logic dbl; logic [5:0] syn;} exp_t;
  exp_t exp_q[$];
  int checks = 0, failures = 0, acc_cnt = 0;

  ecc_secded_pipe #(.DATA_W(32), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_chk(in_chk), .corr_en(corr_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err_single(out_err_single), .out_err_double(out_err_double),
    .out_syndrome(out_syndrome), .cnt_single(cnt_single), .cnt_double(cnt_double),
    .cnt_clr(cnt_clr), .log_valid(log_valid), .log_syndrome(log_syndrome), .log_double(log_double)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [9:0] t;
    t = encode(256'(d), 32);
    return t[6:0];
  endfunction

  // Codeword of 38 positions; syndrome = XOR of indices of every set bit
  function automatic exp_t model(input logic [31:0] d, input logic [6:0] c, input logic ce);
    exp_t e;
    int syn, pos;
    int pm [32];
    logic p;
    syn = 0;
    pos = 2;
    for (int i = 0; i < 6; i++) if (c[i]) syn ^= (1 << i);
    for (int j = 0; j < 32; j++) begin
      pos++;
      while ((pos & (pos - 1)) == 0) pos++;
      pm[j] = pos;
      if (d[j]) syn ^= pos;
    end
    p = ^{d, c};
    e.d = d;
    e.s = p && syn <= 38;
    e.dbl = (p && syn > 38) || (!p && syn != 0);
    e.syn = 6'(syn);
    if (e.s && ce) for (int j = 0; j < 32; j++) if (pm[j] == syn) e.d[j] = ~d[j];
    return e;
  endfunction

  task automatic send(input logic [31:0] d, input logic [6:0] c, input logic ce);
    int n;
    n = 0;
    in_valid = 1; in_data = d; in_chk = c; corr_en = ce;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 50) begin
        check("send_timeout", 1, 0);
        in_valid = 0;
        return;
      end
    end
    exp_q.push_back(model(d, c, ce));
    acc_cnt++;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  // Compare process: output words, stall stability, counters and log each cycle
  exp_t held_v, e;
  logic held = 0, rst_d = 0, got;
  int m_cs = 0, m_cd = 0;
  logic m_lv = 0, m_ld = 0;
  logic [5:0] m_ls = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (rst_d) check("reset_state", {out_valid, out_data, out_err_single, out_err_double, out_syndrome,
                                       cnt_single, cnt_double, log_valid, log_syndrome, log_double}, '0);
      exp_q.delete();
      m_cs = 0; m_cd = 0; m_lv = 0; m_ls = 0; m_ld = 0;
      held = 0;
    end else begin
      got = 0;
      if (held) check("stall_stable", {out_valid, out_data, out_err_single, out_err_double, out_syndrome},
                      {1'b1, held_v});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          got = 1;
          check("out_data", out_data, e.d);
          check("out_err_single", out_err_single, e.s);
          check("out_err_double", out_err_double, e.dbl);
          check("out_syndrome", out_syndrome, e.syn);
        end
      end
      check("cnt_single", cnt_single, m_cs);
      check("cnt_double", cnt_double, m_cd);
      check("log", {log_valid, log_syndrome, log_double}, {m_lv, m_ls, m_ld});
      if (cnt_clr) begin
        m_cs = 0; m_cd = 0; m_lv = 0; m_ls = 0; m_ld = 0;
      end else if (got) begin
        if (e.s && m_cs < 3) m_cs++;
        if (e.dbl && m_cd < 3) m_cd++;
        if (!m_lv && (e.s || e.dbl)) begin
          m_lv = 1; m_ls = e.syn; m_ld = e.dbl;
        end
      end
      held = out_valid && !out_ready;
      held_v = {out_data, out_err_single, out_err_double, out_syndrome};
    end
    rst_d = rst;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  localparam logic [31:0] A5 = 32'hA5A5A5A5;
  initial begin
    exp_t pe;
    int n;
    logic [31:0] w [4];
    w[0] = 32'h12345678; w[1] = 32'hDEADBEEF; w[2] = 32'h0F0F0F0F; w[3] = 32'h80000001;
    check("pin_enc_1", enc(32'h1), 7'h43);
    pe = model(32'h0, 7'h0, 1);
    check("pin_zero", pe, {32'h0, 1'b0, 1'b0, 6'h00});
    pe = model(A5 ^ 32'h80, enc(A5), 1);
    check("pin_single", pe, {32'hA5A5A5A5, 1'b1, 1'b0, 6'h0C});
    pe = model(A5 ^ 32'h3, enc(A5), 1);
    check("pin_double", pe, {32'hA5A5A5A6, 1'b0, 1'b1, 6'h06});
    pe = model(A5 ^ 32'h80, enc(A5), 0);
    check("pin_nocorr", pe, {32'hA5A5A525, 1'b1, 1'b0, 6'h0C});
    repeat (3) @(posedge clk);
    #1 rst = 0;
    send(32'h0, 7'h0, 1);
    check("lat_not_early", out_valid, 0);
    @(posedge clk); #1;
    check("lat_two", out_valid, 1);
    drain();
    send(A5 ^ 32'h80, enc(A5), 1);
    drain();
    check("first_single_cnt", cnt_single, 1);
    check("first_log", {log_valid, log_syndrome, log_double}, {1'b1, 6'h0C, 1'b0});
    send(A5 ^ 32'h3, enc(A5), 1);
    drain();
    check("first_double_cnt", cnt_double, 1);
    check("log_held", log_syndrome, 6'h0C);
    send(A5 ^ 32'h80, enc(A5), 0);
    send(A5, enc(A5) ^ 7'h04, 1);
    send(A5, enc(A5) ^ 7'h40, 1);
    send(A5, enc(A5) ^ 7'h2C, 1);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] d;
      d = $urandom;
      send(i[0] ? d ^ (32'h1 << (i * 5)) : d, enc(d), 1);
    end
    drain();
    @(posedge clk); #1 out_ready = 0;
    n = acc_cnt;
    fork
      for (int i = 0; i < 4; i++) send(w[i], enc(w[i]) ^ (i == 2 ? 7'h01 : 7'h00), 1);
      begin
        repeat (5) @(posedge clk);
        #2;
        check("stall_in_ready", in_ready, 0);
        check("stall_accepted", acc_cnt - n, 2);
        out_ready = 1;
      end
    join
    drain();
    cnt_clr = 1;
    @(posedge clk); #1 cnt_clr = 0;
    check("clr_cnt", {cnt_single, cnt_double, log_valid}, 0);
    for (int i = 0; i < 5; i++) send(A5 ^ (32'h1 << i), enc(A5), 1);
    drain();
    check("sat_cnt", cnt_single, 3);
    out_ready = 0;
    send(A5 ^ 32'h20, enc(A5), 1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("sixth_ready", out_valid, 1);
    cnt_clr = 1; out_ready = 1;
    @(posedge clk); #1 cnt_clr = 0;
    check("clr_wins_cnt", cnt_single, 0);
    check("clr_wins_log", log_valid, 0);
    send(A5 ^ 32'h300, enc(A5), 1);
    drain();
    check("log_after_clr", {log_valid, log_double, cnt_double}, {1'b1, 1'b1, 2'd1});
    out_ready = 0;
    send(w[0], enc(w[0]), 1);
    send(w[1], enc(w[1]), 1);
    rst = 1;
    check("rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0; out_ready = 1;
    check("rst_flush", out_valid, 0);
    send(w[3], enc(w[3]) ^ 7'h20, 1);
    drain();
    check("post_rst_cnt", cnt_single, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
